// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, talks to instruction
// memory (one request outstanding at most), keeps a one-deep prefetch of pc+4
// and loads the IF/ID register under hazard-unit control.
// Optional build macro FETCH_MISALIGN_EN: misaligned redirect targets are
// taken without fetching and flagged through ifid_misaligned; otherwise the
// redirect target is forced to a word boundary.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_write_enable,
  input  logic        ifid_write_enable,
  input  logic        pipe_enable,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_wait,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instruction,
`ifdef FETCH_MISALIGN_EN
  output logic        ifid_misaligned,
`endif
  output logic        ifid_valid
);

  typedef enum logic [2:0] {
    S_FETCH,  // buf empty, nothing outstanding
    S_WAIT,   // request for pc outstanding
    S_PREF,   // buf valid, nothing outstanding, prefetching pc+4
    S_PWAIT,  // buf valid, request for pc+4 outstanding
    S_PFULL,  // buf and pbuf valid
    S_DROP    // stale response outstanding after a redirect
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pbuf_q, pbuf_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        buf_valid, advance, accept, req_block, buf_load;
  logic [31:0] pc_plus4, target_eff, next_pc;

`ifdef FETCH_MISALIGN_EN
  logic buf_mis_q, buf_mis_d;
  logic stale_q, stale_d;
  logic ifid_mis_q, ifid_mis_d;
  logic misalign_redirect;
`endif

  // Pipeline handshakes, PC arithmetic and memory request outputs
  always_comb begin
    buf_valid = (state_q == S_PREF) || (state_q == S_PWAIT) || (state_q == S_PFULL);
    advance   = pipe_enable && pc_write_enable && buf_valid;
    pc_plus4  = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_EN
    target_eff        = branch_target;
    misalign_redirect = advance && branch_taken && (branch_target[1:0] != 2'b00);
    // No fetch while a stale response is in flight or buf is a misaligned marker.
    req_block         = stale_q || ((state_q == S_PREF) && buf_mis_q);
`else
    target_eff = branch_target & ~32'h3;
    req_block  = 1'b0;
`endif
    next_pc   = branch_taken ? target_eff : pc_plus4;
    pc_d      = advance ? next_pc : pc_q;
    // reset_n gating keeps the request low for the whole reset assertion.
    imem_req  = reset_n && !req_block && ((state_q == S_FETCH) || (state_q == S_PREF));
    imem_addr = (state_q == S_PREF) ? pc_plus4 : pc_q;
    accept    = imem_req && imem_ready;
    imem_wait = !buf_valid;
  end

  // Fetch FSM next state and instruction buffer updates
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pbuf_d   = pbuf_q;
    buf_load = 1'b0;
    case (state_q)
      S_FETCH: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          buf_d    = imem_rdata;
          buf_load = 1'b1;
          state_d  = S_PREF;
        end
      end
      S_PREF: begin
        if (advance) begin
          // An accepted pc+4 request becomes the fetch of the new pc, or is stale.
          if (accept) state_d = branch_taken ? S_DROP : S_WAIT;
          else        state_d = S_FETCH;
        end else if (accept) begin
          state_d = S_PWAIT;
        end
      end
      S_PWAIT: begin
        if (advance) begin
          if (!branch_taken) begin
            if (imem_rvalid) begin
              buf_d    = imem_rdata;
              buf_load = 1'b1;
              state_d  = S_PREF;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = imem_rvalid ? S_FETCH : S_DROP;
          end
        end else if (imem_rvalid) begin
          pbuf_d  = imem_rdata;
          state_d = S_PFULL;
        end
      end
      S_PFULL: begin
        if (advance) begin
          if (!branch_taken) begin
            buf_d    = pbuf_q;
            buf_load = 1'b1;
            state_d  = S_PREF;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DROP:  if (imem_rvalid) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (misalign_redirect) begin
      state_d = S_PREF;
      buf_d   = NOP_INSTR;
    end
`endif
  end

`ifdef FETCH_MISALIGN_EN
  // Misaligned marker and stale-response tracking for misaligned redirects
  always_comb begin
    stale_d   = stale_q && !imem_rvalid;
    buf_mis_d = buf_load ? 1'b0 : buf_mis_q;
    if (misalign_redirect) begin
      buf_mis_d = 1'b1;
      if (((state_q == S_PREF) && accept) || ((state_q == S_PWAIT) && !imem_rvalid))
        stale_d = 1'b1;
    end
  end
`endif

  // IF/ID register load; redirects in the same cycle are squashed downstream
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
`ifdef FETCH_MISALIGN_EN
    ifid_mis_d   = ifid_mis_q;
`endif
    if (pipe_enable && ifid_write_enable) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = buf_valid ? buf_q : NOP_INSTR;
      ifid_valid_d = buf_valid;
`ifdef FETCH_MISALIGN_EN
      ifid_mis_d   = buf_valid && buf_mis_q;
`endif
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_VECTOR;
      buf_q        <= NOP_INSTR;
      pbuf_q       <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      buf_mis_q    <= 1'b0;
      stale_q      <= 1'b0;
      ifid_mis_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      pbuf_q       <= pbuf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_MISALIGN_EN
      buf_mis_q    <= buf_mis_d;
      stale_q      <= stale_d;
      ifid_mis_q   <= ifid_mis_d;
`endif
    end
  end

  assign ifid_pc          = ifid_pc_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_valid       = ifid_valid_q;
`ifdef FETCH_MISALIGN_EN
  assign ifid_misaligned  = ifid_mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed phases followed by a randomized run of the fetch
// stage against an architectural model: a PC that moves only on advance, a
// memory whose word at address a is a fixed function of a, and an in-order
// single-slot responder with random latency.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pipe_enable = 1'b0, pc_write_enable = 1'b0, ifid_write_enable = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_wait;
  logic [31:0] ifid_pc, ifid_instruction;
  logic        ifid_valid;
`ifdef FETCH_MISALIGN_EN
  logic        ifid_misaligned;
`endif

  fetch_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .pc_write_enable(pc_write_enable), .ifid_write_enable(ifid_write_enable),
    .pipe_enable(pipe_enable), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_wait(imem_wait),
    .ifid_pc(ifid_pc), .ifid_instruction(ifid_instruction),
`ifdef FETCH_MISALIGN_EN
    .ifid_misaligned(ifid_misaligned),
`endif
    .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Architectural model state
  logic [31:0] mpc = RV;
  logic [31:0] exp_pc = 32'h0, exp_ins = NOP;
  bit          exp_val = 1'b0;
  // Memory responder state
  bit          pending = 1'b0, pend_stale = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          cnt = 0;
  // Stimulus knobs
  bit          pe, pcwe, ifwe, br, rdy, hold;
  logic [31:0] tgt;
  int          lat_hi = 0;
  // Observations from the latest step
  bit          last_req, last_accept, last_wait;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {1'b1, a[31:2], 1'b1};
  endfunction

  function automatic logic [31:0] b2w(input bit b);
    return {31'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check request side, clock, check IF/ID.
  task automatic step();
    bit rv, acc, adv, rdy_eff;
    rv      = pending && (cnt == 0) && !hold;
    rdy_eff = rdy && !pend_stale;
    pipe_enable       = pe;
    pc_write_enable   = pcwe;
    ifid_write_enable = ifwe;
    branch_taken      = br;
    branch_target     = tgt;
    imem_ready        = rdy_eff;
    imem_rvalid       = rv;
    imem_rdata        = rv ? mem_word(paddr) : $urandom;
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    last_wait = imem_wait;
    if (last_req) begin
      check("one_outstanding", b2w(pending && !pend_stale), 32'd0);
      check("req_addr", last_addr, last_wait ? mpc : mpc + 32'd4);
    end
    acc = last_req && rdy_eff;
    adv = pe && pcwe && !last_wait;
    if (pe && ifwe) begin
      exp_pc  = mpc;
      exp_val = !last_wait;
      exp_ins = last_wait ? NOP : mem_word(mpc);
    end
    @(posedge clk);
    #1;
    check("ifid_pc", ifid_pc, exp_pc);
    check("ifid_instruction", ifid_instruction, exp_ins);
    check("ifid_valid", b2w(ifid_valid), b2w(exp_val));
    if (rv) begin
      pending    = 1'b0;
      pend_stale = 1'b0;
    end else if (pending && cnt > 0) begin
      cnt--;
    end
    if (acc) begin
      pending = 1'b1;
      paddr   = last_addr;
      cnt     = int'($urandom_range(lat_hi, 0));
    end
    if (adv) mpc = br ? (tgt & ~32'h3) : mpc + 32'd4;
    last_accept = acc;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed mid-cycle; called just after a negedge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("rst_req", b2w(imem_req), 32'd0);
    check("rst_wait", b2w(imem_wait), 32'd1);
    check("rst_pc", imem_addr, RV);
    check("rst_ifid_valid", b2w(ifid_valid), 32'd0);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_ifid_ins", ifid_instruction, NOP);
    mpc = RV; exp_pc = 32'h0; exp_ins = NOP; exp_val = 1'b0;
    if (pending) pend_stale = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic all_go();
    pe = 1; pcwe = 1; ifwe = 1; br = 0; tgt = 32'h0; rdy = 1; hold = 0;
  endtask

  // Run until the stage is in steady prefetch (buf held, request up).
  task automatic reach_pref();
    all_go();
    for (int i = 0; i < 20 && !(imem_req && !imem_wait); i++) step();
    check("reach_pref", b2w(imem_req && !imem_wait), 32'd1);
  endtask

  initial begin
    logic [31:0] vpcs[$];
    int first_valid, reqs, accs;
    all_go();
    lat_hi = 0;
    @(negedge clk);
    do_reset();

    // Phase 1: streaming from reset, 1-cycle memory
    first_valid = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ifid_valid) begin
        vpcs.push_back(ifid_pc);
        if (first_valid < 0) first_valid = i;
      end
    end
    check("first_valid_cycle_ge3", b2w(first_valid >= 3), 32'd1);
    check("stream_count", b2w(vpcs.size() >= 3), 32'd1);
    if (vpcs.size() >= 3) begin
      check("stream_pc0", vpcs[0], 32'h0);
      check("stream_pc1", vpcs[1], 32'h4);
      check("stream_pc2", vpcs[2], 32'h8);
    end

    // Phase 2: pipe frozen for 5 cycles in prefetch
    reach_pref();
    pe = 0; reqs = 0; accs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      reqs += int'(last_req);
      accs += int'(last_accept);
    end
    check("freeze_reqs", reqs, 32'd1);
    check("freeze_accepts", accs, 32'd1);
    pe = 1;
    step();
    check("unfreeze_valid0", b2w(ifid_valid), 32'd1);
    step();
    check("unfreeze_valid1", b2w(ifid_valid), 32'd1);

    // Phase 3: redirect to 0x100 with prefetch outstanding, then phase 4 stall
    reach_pref();
    pcwe = 0; hold = 1;
    step();
    pcwe = 1; br = 1; tgt = 32'h100;
    step();
    check("redirect_in_pwait", b2w(last_wait), 32'd0);
    br = 0; hold = 0; rdy = 0;
    step();
    check("drop_no_req", b2w(last_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_req", b2w(last_req), 32'd1);
      check("stall_addr", last_addr, 32'h100);
      check("stall_wait", b2w(last_wait), 32'd1);
    end
    rdy = 1;
    for (int i = 0; i < 6; i++) step();

    // Phase 5: reset while a prefetch is outstanding; late response ignored
    reach_pref();
    pcwe = 0; hold = 1;
    step();
    do_reset();
    all_go();
    step();
    check("post_rst_req", b2w(last_req), 32'd1);
    check("post_rst_addr", last_addr, RV);
    for (int i = 0; i < 8; i++) step();

    // Wrap-around: redirect near the top of the address space
    reach_pref();
    br = 1; tgt = 32'hFFFF_FFFE;
    step();
    br = 0;
    for (int i = 0; i < 10; i++) step();

    // Randomized run
    lat_hi = 2;
    for (int i = 0; i < 2000; i++) begin
      pe   = ($urandom_range(9, 0) != 0);
      pcwe = ($urandom_range(4, 0) != 0);
      ifwe = ($urandom_range(5, 0) != 0);
      br   = ($urandom_range(6, 0) == 0);
      tgt  = $urandom;
      rdy  = ($urandom_range(3, 0) != 0);
      hold = ($urandom_range(4, 0) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
